// File: rtl/word_uart_tx_if.sv
// word_uart_tx_if - CPU-side bus of the 16-bit word UART transmitter.
//
// Signals:
//   wr_en   : write strobe, one word accepted per cycle when not full
//   wr_data : 16-bit word to transmit
//   full    : FIFO holds 2**FIFO_AW words (registered)
//   level   : words waiting in the FIFO, excluding the word being shifted
//   busy    : a frame is in progress
//   tx      : serial line, idle high
//
// Modports: master = CPU / bench side, slave = transmitter side.
interface word_uart_tx_if #(
  parameter int FIFO_AW = 2
);
  logic               wr_en;
  logic [15:0]        wr_data;
  logic               full;
  logic [FIFO_AW:0]   level;
  logic               busy;
  logic               tx;

  modport master (output wr_en, output wr_data,
                  input full, input level, input busy, input tx);
  modport slave  (input wr_en, input wr_data,
                  output full, output level, output busy, output tx);
endinterface

// File: rtl/word_uart_tx.sv
// word_uart_tx - sends 16-bit words queued by the CPU as two 8N1 frames,
// low byte first, on a single UART line.
//
// Ports:
//   clk : system clock, all logic on the rising edge
//   rst : synchronous active-low reset (0 = reset)
//   bus : word_uart_tx_if.slave (wr_en, wr_data in; full, level, busy, tx out)
//
// Parameters:
//   CLK_DIV : clk cycles per serial bit (2..65535)
//   FIFO_AW : FIFO address width, depth = 2**FIFO_AW words
module word_uart_tx #(
  parameter int CLK_DIV = 4,
  parameter int FIFO_AW = 2
) (
  input logic           clk,
  input logic           rst,
  word_uart_tx_if.slave bus
);

  localparam int               DEPTH     = 2 ** FIFO_AW;
  localparam logic [15:0]      BAUD_MAX  = 16'(CLK_DIV - 1);
  localparam logic [FIFO_AW:0] LVL_ZERO  = (FIFO_AW + 1)'(0);
  localparam logic [FIFO_AW:0] LVL_ONE   = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW:0] LVL_FULL  = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [15:0]        baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic               byte_sel_q, byte_sel_d;
  logic [7:0]         shreg_q, shreg_d;   // remaining data bits of current byte
  logic [7:0]         hi_q, hi_d;         // high byte parked while low byte goes out
  logic               tx_q, tx_d;
  logic               busy_q;
  logic               full_q;
  logic [FIFO_AW:0]   level_q, level_d;
  logic [FIFO_AW-1:0] wptr_q, rptr_q;
  logic [15:0]        mem_q [DEPTH];

  logic               push_s;
  logic               pop_s;
  logic               baud_wrap_s;
  logic [15:0]        head_s;

  // Full is judged on the pre-edge count, so a write while full is dropped
  // even if a pop happens on the same edge.
  assign push_s      = bus.wr_en && !full_q;
  assign baud_wrap_s = (baud_q == BAUD_MAX);
  assign head_s      = mem_q[rptr_q];

  assign bus.tx    = tx_q;
  assign bus.busy  = busy_q;
  assign bus.full  = full_q;
  assign bus.level = level_q;

  // FIFO storage; pointers are reset, so stale contents are never read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wptr_q] <= bus.wr_data;
    end
  end

  // Word count: a simultaneous push and pop leaves it unchanged.
  always_comb begin
    level_d = level_q;
    if (push_s && !pop_s) begin
      level_d = level_q + LVL_ONE;
    end else if (pop_s && !push_s) begin
      level_d = level_q - LVL_ONE;
    end else begin
      level_d = level_q;
    end
  end

  // Frame sequencer: next state, baud counter, shifter and line value.
  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    byte_sel_d = byte_sel_q;
    shreg_d    = shreg_q;
    hi_d       = hi_q;
    tx_d       = tx_q;
    pop_s      = 1'b0;
    if ((state_q == S_IDLE) || baud_wrap_s) begin
      baud_d = 16'd0;
    end else begin
      baud_d = baud_q + 16'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (level_q != LVL_ZERO) begin
          pop_s      = 1'b1;
          shreg_d    = head_s[7:0];
          hi_d       = head_s[15:8];
          byte_sel_d = 1'b0;
          bit_d      = 3'd0;
          tx_d       = 1'b0;
          state_d    = S_START;
        end else begin
          tx_d = 1'b1;
        end
      end
      S_START: begin
        if (baud_wrap_s) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
          tx_d    = shreg_q[0];
          shreg_d = {1'b0, shreg_q[7:1]};
        end else begin
          tx_d = 1'b0;
        end
      end
      S_DATA: begin
        if (baud_wrap_s) begin
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            tx_d    = shreg_q[0];
            shreg_d = {1'b0, shreg_q[7:1]};
          end
        end else begin
          tx_d = tx_q;
        end
      end
      S_STOP: begin
        if (baud_wrap_s) begin
          if (!byte_sel_q) begin
            // High byte follows the low byte with no idle gap.
            shreg_d    = hi_q;
            byte_sel_d = 1'b1;
            tx_d       = 1'b0;
            state_d    = S_START;
          end else if (level_q != LVL_ZERO) begin
            pop_s      = 1'b1;
            shreg_d    = head_s[7:0];
            hi_d       = head_s[15:8];
            byte_sel_d = 1'b0;
            bit_d      = 3'd0;
            tx_d       = 1'b0;
            state_d    = S_START;
          end else begin
            tx_d    = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          tx_d = 1'b1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters, pointers and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      baud_q     <= 16'd0;
      bit_q      <= 3'd0;
      byte_sel_q <= 1'b0;
      shreg_q    <= 8'd0;
      hi_q       <= 8'd0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      full_q     <= 1'b0;
      level_q    <= LVL_ZERO;
      wptr_q     <= '0;
      rptr_q     <= '0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      byte_sel_q <= byte_sel_d;
      shreg_q    <= shreg_d;
      hi_q       <= hi_d;
      tx_q       <= tx_d;
      busy_q     <= (state_d != S_IDLE);
      full_q     <= (level_d == LVL_FULL);
      level_q    <= level_d;
      if (push_s) begin
        wptr_q <= wptr_q + PTR_ONE;
      end
      if (pop_s) begin
        rptr_q <= rptr_q + PTR_ONE;
      end
    end
  end

endmodule
